// File: rtl/ped_signal_seq.sv
// ped_signal_seq: pedestrian-signal sequencer feeding the 8x8 LED matrix driver.
// Runs STOP -> WALK -> FLASH. An internal tick divider sets the time base, and
// every output is registered.
// Optional build macro PED_AUTO_CYCLE_EN: when it is defined, STOP leaves after
// exactly STOP_T ticks without waiting for a button request.
module ped_signal_seq #(
   parameter int TICK_DIV = 12500000,
   parameter int STOP_T   = 40,
   parameter int WALK_T   = 60,
   parameter int FLASH_T  = 20,
   parameter int FRAME_T  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_req,
   output logic       pattern,
   output logic [1:0] sel,
   output logic       blank,
   output logic       req_pending,
   output logic [7:0] remain
);

   localparam int DW = $clog2(TICK_DIV);
   localparam int FW = (FRAME_T > 1) ? $clog2(FRAME_T) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_T - 1);
   localparam logic [7:0]    STOP_LEN   = 8'(STOP_T);
   localparam logic [7:0]    WALK_LEN   = 8'(WALK_T);
   localparam logic [7:0]    FLASH_LEN  = 8'(FLASH_T);
`ifdef PED_AUTO_CYCLE_EN
   localparam logic AUTO_CYCLE = 1'b1;
`else
   localparam logic AUTO_CYCLE = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_WALK  = 2'b01,
      ST_FLASH = 2'b10
   } state_t;

   state_t          state_r, state_nx_s;
   logic [DW-1:0]   div_r;
   logic [FW-1:0]   frame_r, frame_nx_s, frame_adv_s;
   logic [7:0]      remain_r, remain_nx_s;
   logic [1:0]      sel_r, sel_nx_s, sel_adv_s;
   logic            pattern_r, pattern_nx_s;
   logic            blank_r, blank_nx_s;
   logic            req_r, req_nx_s;
   logic            btn_q_r;
   logic            tick_s;
   logic            edge_s;
   logic            go_walk_s;

   assign tick_s = (div_r == DIV_LAST);
   assign edge_s = btn_req & ~btn_q_r;

   // Free-running tick divider; wraps to zero on the tick cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_r <= '0;
      end else if (tick_s) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DW'(1);
      end
   end

   // Previous-cycle button sample for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q_r <= 1'b0;
      end else begin
         btn_q_r <= btn_req;
      end
   end

   // STOP ends on a tick at remain 1 with a request (auto-cycle counts as one), or at remain 0 with a request.
   always_comb begin
      go_walk_s = 1'b0;
      if (tick_s && (state_r == ST_STOP)) begin
         if (remain_r == 8'd1) begin
            go_walk_s = req_r | AUTO_CYCLE;
         end else if (remain_r == 8'd0) begin
            go_walk_s = req_r;
         end else begin
            go_walk_s = 1'b0;
         end
      end else begin
         go_walk_s = 1'b0;
      end
   end

   // Animation step: the frame counter wraps at FRAME_T-1 and then advances sel modulo 4.
   always_comb begin
      frame_adv_s = frame_r;
      sel_adv_s   = sel_r;
      if (frame_r == FRAME_LAST) begin
         frame_adv_s = '0;
         sel_adv_s   = sel_r + 2'd1;
      end else begin
         frame_adv_s = frame_r + FW'(1);
         sel_adv_s   = sel_r;
      end
   end

   // Next-state and next-output logic for the phase sequencer.
   always_comb begin
      state_nx_s   = state_r;
      remain_nx_s  = remain_r;
      pattern_nx_s = pattern_r;
      sel_nx_s     = sel_r;
      blank_nx_s   = blank_r;
      req_nx_s     = req_r;
      frame_nx_s   = frame_r;
      case (state_r)
         ST_STOP: begin
            if (go_walk_s) begin
               state_nx_s   = ST_WALK;
               remain_nx_s  = WALK_LEN;
               pattern_nx_s = 1'b1;
               sel_nx_s     = 2'd0;
               frame_nx_s   = '0;
               blank_nx_s   = 1'b0;
               req_nx_s     = 1'b0;
            end else begin
               pattern_nx_s = 1'b0;
               sel_nx_s     = 2'd0;
               blank_nx_s   = 1'b0;
               frame_nx_s   = '0;
               req_nx_s     = req_r | edge_s;
               if (tick_s && (remain_r > 8'd1)) begin
                  remain_nx_s = remain_r - 8'd1;
               end else if (tick_s) begin
                  remain_nx_s = 8'd0;
               end else begin
                  remain_nx_s = remain_r;
               end
            end
         end
         ST_WALK: begin
            if (tick_s) begin
               sel_nx_s   = sel_adv_s;
               frame_nx_s = frame_adv_s;
               if (remain_r <= 8'd1) begin
                  state_nx_s  = ST_FLASH;
                  remain_nx_s = FLASH_LEN;
                  blank_nx_s  = 1'b1;
               end else begin
                  remain_nx_s = remain_r - 8'd1;
               end
            end else begin
               remain_nx_s = remain_r;
            end
         end
         ST_FLASH: begin
            if (tick_s && (remain_r <= 8'd1)) begin
               state_nx_s   = ST_STOP;
               remain_nx_s  = STOP_LEN;
               pattern_nx_s = 1'b0;
               sel_nx_s     = 2'd0;
               frame_nx_s   = '0;
               blank_nx_s   = 1'b0;
            end else if (tick_s) begin
               remain_nx_s = remain_r - 8'd1;
               blank_nx_s  = ~blank_r;
               sel_nx_s    = sel_adv_s;
               frame_nx_s  = frame_adv_s;
            end else begin
               remain_nx_s = remain_r;
            end
         end
         default: begin
            state_nx_s   = ST_STOP;
            remain_nx_s  = STOP_LEN;
            pattern_nx_s = 1'b0;
            sel_nx_s     = 2'd0;
            blank_nx_s   = 1'b0;
            req_nx_s     = 1'b0;
            frame_nx_s   = '0;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_STOP;
         remain_r  <= STOP_LEN;
         pattern_r <= 1'b0;
         sel_r     <= 2'd0;
         blank_r   <= 1'b0;
         req_r     <= 1'b0;
         frame_r   <= '0;
      end else begin
         state_r   <= state_nx_s;
         remain_r  <= remain_nx_s;
         pattern_r <= pattern_nx_s;
         sel_r     <= sel_nx_s;
         blank_r   <= blank_nx_s;
         req_r     <= req_nx_s;
         frame_r   <= frame_nx_s;
      end
   end

   assign pattern     = pattern_r;
   assign sel         = sel_r;
   assign blank       = blank_r;
   assign req_pending = req_r;
   assign remain      = remain_r;

endmodule

// File: tb/tb_ped_signal_seq.sv
// Bench for ped_signal_seq. A phase/elapsed-tick model checks every cycle,
// and directed scenarios compare against hand-computed values.
module tb_ped_signal_seq;

   localparam int TICK_DIV = 4;
   localparam int STOP_T   = 3;
   localparam int WALK_T   = 8;
   localparam int FLASH_T  = 4;
   localparam int FRAME_T  = 2;
`ifdef PED_AUTO_CYCLE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam int P_STOP  = 0;
   localparam int P_WALK  = 1;
   localparam int P_FLASH = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_req;
   logic       pattern;
   logic [1:0] sel;
   logic       blank;
   logic       req_pending;
   logic [7:0] remain;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ped_signal_seq #(
      .TICK_DIV(TICK_DIV), .STOP_T(STOP_T), .WALK_T(WALK_T),
      .FLASH_T(FLASH_T), .FRAME_T(FRAME_T)
   ) dut (
      .clk(clk), .rst(rst), .btn_req(btn_req), .pattern(pattern),
      .sel(sel), .blank(blank), .req_pending(req_pending), .remain(remain)
   );

   // Model state: the current phase, the ticks spent in it, the ticks since
   // WALK was entered, and whether a request is pending.
   typedef struct {
      int ph;
      int el;
      int an;
      bit pd;
   } mstate_t;

   mstate_t m;
   int      m_cyc;
   bit      m_prev;

   function automatic mstate_t model_step(mstate_t s, bit ed, bit tk);
      mstate_t n;
      bit go;
      n  = s;
      go = 1'b0;
      if (tk) begin
         n.el = s.el + 1;
         if (s.ph == P_STOP) begin
            go = (n.el >= STOP_T && s.pd) || (AUTO && n.el == STOP_T);
         end else begin
            n.an = s.an + 1;
            if (s.ph == P_WALK && n.el == WALK_T) begin
               n.ph = P_FLASH; n.el = 0;
            end else if (s.ph == P_FLASH && n.el == FLASH_T) begin
               n.ph = P_STOP; n.el = 0; n.an = 0;
            end
         end
      end
      if (s.ph == P_STOP && ed) n.pd = 1'b1;
      if (go) begin
         n.ph = P_WALK; n.el = 0; n.an = 0; n.pd = 1'b0;
      end
      return n;
   endfunction

   function automatic int exp_remain(mstate_t s);
      if (s.ph == P_WALK)  return WALK_T - s.el;
      if (s.ph == P_FLASH) return FLASH_T - s.el;
      return (s.el >= STOP_T) ? 0 : STOP_T - s.el;
   endfunction

   function automatic int exp_sel(mstate_t s);
      if (s.ph == P_STOP) return 0;
      return (s.an / FRAME_T) % 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference model on each clock edge; reset clears it at once.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m      <= '{P_STOP, 0, 0, 1'b0};
         m_cyc  <= 0;
         m_prev <= 1'b0;
      end else begin
         m      <= model_step(m, btn_req && !m_prev, ((m_cyc + 1) % TICK_DIV) == 0);
         m_cyc  <= m_cyc + 1;
         m_prev <= btn_req;
      end
   end

   // Compare every DUT output with the model on each falling edge.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("m_remain",  32'(remain),      32'(exp_remain(m)));
         chk("m_pattern", 32'(pattern),     32'(m.ph != P_STOP));
         chk("m_sel",     32'(sel),         32'(exp_sel(m)));
         chk("m_blank",   32'(blank),       32'(m.ph == P_FLASH && (m.el % 2) == 0));
         chk("m_req",     32'(req_pending), 32'(m.pd));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #($urandom_range(1, 3));
      rst = 1'b0;
      #1;
      chk("rst_pattern", 32'(pattern),     32'd0);
      chk("rst_sel",     32'(sel),         32'd0);
      chk("rst_blank",   32'(blank),       32'd0);
      chk("rst_remain",  32'(remain),      32'd3);
      chk("rst_req",     32'(req_pending), 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
   endtask

   // Press the button for one clock: it is high at exactly one rising edge.
   task automatic press();
      @(negedge clk);
      btn_req = 1'b1;
      @(negedge clk);
      btn_req = 1'b0;
   endtask

   logic [1:0] walk_sel[8];
   logic [1:0] flash_sel[4];
   logic       flash_blank[4];

   initial begin
      walk_sel    = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      flash_sel   = '{2'd0, 2'd0, 2'd1, 2'd1};
      flash_blank = '{1'b1, 1'b0, 1'b1, 1'b0};
      rst     = 1'b0;
      btn_req = 1'b0;
      #22;
      do_reset();

`ifndef PED_AUTO_CYCLE_EN
      // With no button, STOP counts down to 0 and holds there.
      repeat (40) @(negedge clk);
      chk("idle_remain",  32'(remain),      32'd0);
      chk("idle_pattern", 32'(pattern),     32'd0);
      chk("idle_req",     32'(req_pending), 32'd0);

      // A request at edge 2 is taken by the third tick (edge 12) into WALK.
      do_reset();
      @(negedge clk);
      btn_req = 1'b1;
      @(negedge clk);
      btn_req = 1'b0;
      chk("req_latched", 32'(req_pending), 32'd1);
      repeat (10) @(negedge clk);
      chk("walk_pattern", 32'(pattern),     32'd1);
      chk("walk_req",     32'(req_pending), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("walk_sel",    32'(sel),    32'(walk_sel[i]));
         chk("walk_remain", 32'(remain), 32'(8 - i));
         repeat (4) @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         chk("flash_remain", 32'(remain), 32'(4 - i));
         chk("flash_blank",  32'(blank),  32'(flash_blank[i]));
         chk("flash_sel",    32'(sel),    32'(flash_sel[i]));
         repeat (4) @(negedge clk);
      end
      chk("back_remain",  32'(remain),  32'd3);
      chk("back_pattern", 32'(pattern), 32'd0);

      // Presses during WALK and FLASH are ignored, so STOP holds at 0.
      do_reset();
      press();
      repeat (20) @(negedge clk);
      press();
      repeat (24) @(negedge clk);
      press();
      repeat (60) @(negedge clk);
      chk("ign_req",     32'(req_pending), 32'd0);
      chk("ign_remain",  32'(remain),      32'd0);
      chk("ign_pattern", 32'(pattern),     32'd0);

      // Reset in the middle of FLASH.
      do_reset();
      press();
      repeat (48) @(negedge clk);
      chk("midflash_pattern", 32'(pattern), 32'd1);
      do_reset();
`else
      // Auto-cycle: WALK begins at edges 12 and 72, one 60-clk period apart.
      repeat (12) @(negedge clk);
      chk("auto_walk1",  32'(pattern), 32'd1);
      chk("auto_rem1",   32'(remain),  32'd8);
      repeat (48) @(negedge clk);
      chk("auto_stop",   32'(pattern), 32'd0);
      chk("auto_rem2",   32'(remain),  32'd3);
      repeat (12) @(negedge clk);
      chk("auto_walk2",  32'(pattern), 32'd1);
      chk("auto_rem3",   32'(remain),  32'd8);
`endif

      // Random button activity at varying densities, with occasional resets.
      for (int blk = 0; blk < 12; blk++) begin
         int p;
         p = $urandom_range(0, 30);
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            btn_req = ($urandom_range(0, 99) < p);
         end
         if (blk % 4 == 3) do_reset();
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ped_signal_seq.md
Name: ped_signal_seq

Overview:
- Pedestrian-signal sequencer; sits directly upstream of the 8x8 LED matrix driver.
- Produces that driver's `pattern` input (0 = standing figure, 1 = walking figure) and its `sel[1:0]` animation-frame select.
- Also produces a blanking strobe for the flashing phase, a request-pending indicator and a remaining-time count for the countdown display.
- Time base is an internal tick divider.

Parameters:
- TICK_DIV, 12500000: clk cycles per tick (0.25 s at 50 MHz); legal range 2 or more.
- STOP_T, 40: ticks of minimum stop phase; 1..255.
- WALK_T, 60: ticks of walk phase; 1..255.
- FLASH_T, 20: ticks of flashing-walk phase; 1..255.
- FRAME_T, 2: ticks per animation frame; 1 or more.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- btn_req, input, 1: pedestrian button, synchronous level; its rising edge is a request.
- pattern, output, 1: 0 = stop figure, 1 = walk figure.
- sel, output, 2: animation frame 0..3.
- blank, output, 1: 1 = downstream column data must be forced to zero.
- req_pending, output, 1: a latched request is waiting.
- remain, output, 8: ticks left in the current phase.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state STOP, remain = STOP_T, pattern = 0, sel = 0, blank = 0, req_pending = 0.
  - Divider = 0, frame counter = 0, button-edge register = 0.
- Tick divider:
  - Free-running counter 0..TICK_DIV-1, wraps to 0.
  - tick is an internal 1-cycle pulse while the counter equals TICK_DIV-1.
  - First tick falls on the TICK_DIV-th rising edge after reset release.
- All outputs are registered; state, remain, sel and blank change only on tick cycles. Exception: req_pending also sets on a button edge.
- Request latch:
  - Rising edge = btn_req = 1 while the previous-cycle sample = 0.
  - An edge in STOP sets req_pending on the next clk edge, independent of tick.
  - Edges in WALK or FLASH are ignored.
  - req_pending clears on entry to WALK.
  - If an edge and the STOP-to-WALK transition fall in the same cycle, the transition wins and req_pending = 0.
- State STOP (pattern = 0, sel = 0, blank = 0):
  - On tick with remain > 1: remain decrements.
  - On tick with remain = 1 and req_pending = 1: go to WALK.
  - On tick with remain = 1 and req_pending = 0: remain = 0.
  - On tick with remain = 0 and req_pending = 1: go to WALK. remain holds at 0 while no request.
- Entry to WALK: remain = WALK_T, pattern = 1, sel = 0, frame counter = 0, blank = 0.
- State WALK:
  - Each tick: remain decrements; frame counter increments.
  - When the frame counter reaches FRAME_T-1 on a tick, it returns to 0 and sel increments modulo 4 (3 to 0 wraps).
  - On tick with remain = 1: go to FLASH.
- Entry to FLASH: remain = FLASH_T, pattern = 1; sel and frame counter continue without reset; blank = 1.
- State FLASH:
  - Each tick: blank toggles; sel keeps advancing as in WALK.
  - On tick with remain = 1: go to STOP, with remain = STOP_T, pattern = 0, sel = 0, blank = 0.
- Phase lengths: WALK lasts exactly WALK_T ticks; FLASH exactly FLASH_T ticks; STOP at least STOP_T ticks.
- Reset asserted mid-phase returns everything to the reset values immediately; a pending request is lost.
- Illegal state encoding recovers to STOP with the reset values on the next clk.

Optional Feature:
- PED_AUTO_CYCLE_EN defined: STOP treats req_pending as permanently 1 when a tick arrives with remain = 1. The controller then cycles STOP to WALK to FLASH continuously with STOP exactly STOP_T ticks. The req_pending output still reflects button edges and clears on WALK entry.
- Undefined: WALK is entered only after a request, as above.

Test Plan:
Test parameters for all scenarios: TICK_DIV = 4, STOP_T = 3, WALK_T = 8, FLASH_T = 4, FRAME_T = 2.
- Release reset, no button, 40 clk -> STOP held; remain sequence 3, 2, 1, 0 at ticks 0..3, then stays 0; pattern = 0, sel = 0, req_pending = 0.
- Pulse btn_req for 1 clk at clk 2 -> req_pending = 1 at clk 3; the 3rd tick enters WALK: pattern = 1, remain = 8, req_pending = 0; sel runs 0, 0, 1, 1, 2, 2, 3, 3 over the 8 WALK ticks.
- Continue the previous scenario -> FLASH: remain = 4; blank runs 1, 0, 1, 0; sel continues 0, 0, 1, 1; then STOP with remain = 3, pattern = 0, sel = 0, blank = 0.
- Press the button during WALK and again during FLASH -> req_pending stays 0; after FLASH, STOP counts to 0 and holds, with no WALK entry.
- Assert rst mid-FLASH, between clk edges -> outputs immediately pattern = 0, sel = 0, blank = 0, remain = 3, req_pending = 0.
- Build with PED_AUTO_CYCLE_EN, no button -> repeating 3-tick STOP, 8-tick WALK, 4-tick FLASH cycle (15 ticks = 60 clk period).
